// File: rtl/vga_pkg.sv
// Shared timing constants, widths and vertical phase encoding
// for the VGA controller.
package vga_pkg;
  localparam int H_SYNC  = 96;
  localparam int H_BACK  = 48;
  localparam int H_VALID = 640;
  localparam int H_FRONT = 16;
  localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;

  localparam int V_SYNC  = 2;
  localparam int V_BACK  = 33;
  localparam int V_VALID = 480;
  localparam int V_FRONT = 10;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

  localparam int H_ACT_START = H_SYNC + H_BACK;
  localparam int V_ACT_START = V_SYNC + V_BACK;

  localparam int CNT_W = 10;
  localparam int RGB_W = 12;
  localparam int KEY_W = 8;

  typedef enum logic [1:0] {
    V_SYNC_S   = 2'd0,
    V_BACK_S   = 2'd1,
    V_ACTIVE_S = 2'd2,
    V_FRONT_S  = 2'd3
  } vstate_e;
endpackage

// File: rtl/vga_timing_cnt.sv
// Horizontal/vertical counters and the vertical phase FSM
// that steps on line boundaries.
module vga_timing_cnt
  import vga_pkg::*;
#(
  parameter int HS = H_SYNC,
  parameter int HB = H_BACK,
  parameter int HV = H_VALID,
  parameter int HF = H_FRONT,
  parameter int VS = V_SYNC,
  parameter int VB = V_BACK,
  parameter int VV = V_VALID,
  parameter int VF = V_FRONT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o,
  output vstate_e          state_o
);
  localparam logic [CNT_W-1:0] H_LAST =
    CNT_W'(HS + HB + HV + HF - 1);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(VS - 1);
  localparam logic [CNT_W-1:0] V_BACK_END = CNT_W'(VS + VB - 1);
  localparam logic [CNT_W-1:0] V_ACT_END =
    CNT_W'(VS + VB + VV - 1);
  localparam logic [CNT_W-1:0] V_LAST =
    CNT_W'(VS + VB + VV + VF - 1);

  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  vstate_e          st_q;
  logic             eol;

  assign eol = (h_q == H_LAST);

  always_comb begin
    h_d = eol ? '0 : h_q + 1'b1;
    v_d = v_q;
    if (eol) v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q  <= '0;
      v_q  <= '0;
      st_q <= V_SYNC_S;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
      if (eol) begin
        unique case (st_q)
          V_SYNC_S:
            if (v_q == V_SYNC_END) st_q <= V_BACK_S;
          V_BACK_S:
            if (v_q == V_BACK_END) st_q <= V_ACTIVE_S;
          V_ACTIVE_S:
            if (v_q == V_ACT_END) st_q <= V_FRONT_S;
          V_FRONT_S:
            if (v_q == V_LAST) st_q <= V_SYNC_S;
          default: st_q <= V_SYNC_S;
        endcase
      end
    end
  end

  assign h_cnt_o = h_q;
  assign v_cnt_o = v_q;
  assign state_o = st_q;
endmodule

// File: rtl/vga_ctrl.sv
// VGA 640x480@60 controller: syncs, early pixel request, rgb gate, key path.
// Define VGA_KEY_FRAME_SYNC_EN to move key codes only at frame start.
module vga_ctrl
  import vga_pkg::*;
#(
  parameter int HS = H_SYNC,
  parameter int HB = H_BACK,
  parameter int HV = H_VALID,
  parameter int HF = H_FRONT,
  parameter int VS = V_SYNC,
  parameter int VB = V_BACK,
  parameter int VV = V_VALID,
  parameter int VF = V_FRONT
) (
  input  logic             vga_clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_code_in,
  input  logic             key_valid,
  input  logic [RGB_W-1:0] pix_data_in,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             pix_req,
  output logic [KEY_W-1:0] key_code_out,
  output logic             hsync,
  output logic             vsync,
  output logic [RGB_W-1:0] rgb,
  output logic             frame_start
);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(HS);
  localparam logic [CNT_W-1:0] REQ_LO = CNT_W'(HS + HB - 1);
  localparam logic [CNT_W-1:0] REQ_HI = CNT_W'(HS + HB + HV - 2);
  localparam logic [CNT_W-1:0] VA0 = CNT_W'(VS + VB);
  localparam logic [CNT_W-1:0] H_LAST =
    CNT_W'(HS + HB + HV + HF - 1);
  localparam logic [CNT_W-1:0] V_LAST =
    CNT_W'(VS + VB + VV + VF - 1);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  vstate_e          vstate;
  logic             line_act;
  logic             act_q, fs_q;
  logic [KEY_W-1:0] key_q, key_d;

  vga_timing_cnt #(
    .HS(HS), .HB(HB), .HV(HV), .HF(HF),
    .VS(VS), .VB(VB), .VV(VV), .VF(VF)
  ) u_cnt (
    .clk_i  (vga_clk),
    .rst_i  (rst),
    .h_cnt_o(h_cnt),
    .v_cnt_o(v_cnt),
    .state_o(vstate)
  );

  assign line_act = (vstate == V_ACTIVE_S);
  assign hsync    = rst | (h_cnt >= HS_END);
  assign vsync    = rst | (vstate != V_SYNC_S);
  assign pix_req  = line_act && (h_cnt >= REQ_LO)
                    && (h_cnt <= REQ_HI);
  assign pix_x    = pix_req ? h_cnt - REQ_LO : '0;
  assign pix_y    = line_act ? v_cnt - VA0 : '0;

  // Generator output is already registered; act_q delays the
  // request window by the same cycle so both line up.
  assign rgb          = act_q ? pix_data_in : '0;
  assign frame_start  = fs_q;
  assign key_code_out = key_q;

`ifdef VGA_KEY_FRAME_SYNC_EN
  logic [KEY_W-1:0] hold_q, hold_d;

  always_comb begin
    hold_d = key_valid ? key_code_in : hold_q;
    key_d  = key_q;
    if (h_cnt == '0 && v_cnt == '0) key_d = hold_d;
  end

  always_ff @(posedge vga_clk) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end
`else
  always_comb key_d = key_valid ? key_code_in : key_q;
`endif

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      act_q <= 1'b0;
      fs_q  <= 1'b0;
      key_q <= '0;
    end else begin
      act_q <= pix_req;
      fs_q  <= (h_cnt == H_LAST) && (v_cnt == V_LAST);
      key_q <= key_d;
    end
  end
endmodule

// File: tb/tb_vga_ctrl.sv
// Self-checking bench for vga_ctrl: per-cycle compare against a
// frame-arithmetic model plus literal spot checks.
module tb_vga_ctrl;
  localparam int HT = 800;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int VV = 20;
  localparam int VF = 2;
  localparam int VT = VS + VB + VV + VF;
  localparam int FT = HT * VT;
  localparam int VA0 = VS + VB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  kin = 8'h00;
  logic        kv = 1'b0;
  logic [11:0] gen_q = 12'h000;
  logic [11:0] mask = 12'h000;
  logic [11:0] mask_q = 12'h000;
  bit          rnd_on = 1'b0;

  logic [9:0]  px, py;
  logic        req, hs, vs, fs;
  logic [7:0]  kout;
  logic [11:0] rgb;

  int checks = 0;
  int failures = 0;
  int shown = 0;

  int          t = 0;
  bit          edged = 1'b0;
  bit          rst_at_edge = 1'b0;
  logic [7:0]  ek = 8'h00;
  logic [7:0]  ehold = 8'h00;

  always #20 clk = ~clk;

  vga_ctrl #(.VS(VS), .VB(VB), .VV(VV), .VF(VF)) dut (
    .vga_clk     (clk),
    .rst         (rst),
    .key_code_in (kin),
    .key_valid   (kv),
    .pix_data_in (gen_q),
    .pix_x       (px),
    .pix_y       (py),
    .pix_req     (req),
    .key_code_out(kout),
    .hsync       (hs),
    .vsync       (vs),
    .rgb         (rgb),
    .frame_start (fs)
  );

  // Pixel generator: registered {2'b0, pix_x}, optionally scrambled.
  always @(posedge clk) begin
    gen_q  <= {2'b00, px} ^ mask;
    mask_q <= mask;
  end

  // Model: t = cycles since the last reset edge.
  always @(posedge clk) begin
    edged = 1'b1;
    rst_at_edge = rst;
    if (rst) begin
      t = 0;
      ek = 8'h00;
      ehold = 8'h00;
    end else begin
`ifdef VGA_KEY_FRAME_SYNC_EN
      if (t % FT == 0) ek = kv ? kin : ehold;
      if (kv) ehold = kin;
`else
      if (kv) ek = kin;
`endif
      t++;
    end
  end

  function automatic int cur_h();
    return t % HT;
  endfunction

  function automatic int cur_v();
    return (t / HT) % VT;
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0d", name, got, want, t);
    end
  endtask

  always @(negedge clk) begin
    int h, v;
    bit al;
    logic [43:0] e, g;
    if (edged && !(rst && !rst_at_edge)) begin
      h  = cur_h();
      v  = cur_v();
      al = (v >= VA0) && (v < VA0 + VV);
      e[43] = rst ? 1'b1 : (h >= 96);
      e[42] = rst ? 1'b1 : (v >= VS);
      e[41] = al && (h >= 143) && (h <= 782);
      e[40:31] = e[41] ? 10'(h - 143) : 10'd0;
      e[30:21] = al ? 10'(v - VA0) : 10'd0;
      e[20:9] = (al && h >= 144 && h <= 783) ?
                (12'(h - 144) ^ mask_q) : 12'h000;
      e[8] = (t > 0) && (t % FT == 0);
      e[7:0] = ek;
      g = {hs, vs, req, px, py, rgb, fs, kout};
      checks++;
      if (g !== e) begin
        failures++;
        if (shown < 20) begin
          shown++;
          $display("FAIL cycle_cmp t=%0d h=%0d v=%0d got=%h want=%h",
                   t, h, v, g, e);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_on) begin
      mask = 12'($urandom);
      kv   = ($urandom % 64) == 0;
      kin  = 8'($urandom);
    end
  end

  task automatic goto(input int h, input int v);
    int n = 0;
    @(negedge clk);
    while (!(cur_h() == h && cur_v() == v)) begin
      @(negedge clk);
      n++;
      if (n > FT + 10) begin
        checks++;
        failures++;
        $display("FAIL goto_timeout got=%0d/%0d want=%0d/%0d",
                 cur_h(), cur_v(), h, v);
        return;
      end
    end
  endtask

  task automatic quiet();
    rnd_on = 1'b0;
    @(posedge clk);
    #2;
    kv = 1'b0;
    mask = 12'h000;
  endtask

  initial begin
    int n;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_hsync", 32'(hs), 32'd1);
    chk("rst_vsync", 32'(vs), 32'd1);
    chk("rst_rgb", 32'(rgb), 32'd0);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_key", 32'(kout), 32'd0);
    chk("rst_fs", 32'(fs), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rel_hsync", 32'(hs), 32'd0);
    chk("rel_vsync", 32'(vs), 32'd0);

    goto(95, 0);  chk("hs_95", 32'(hs), 32'd0);
    goto(96, 0);  chk("hs_96", 32'(hs), 32'd1);
    goto(799, 1); chk("vs_l1", 32'(vs), 32'd0);
    goto(0, 2);   chk("vs_l2", 32'(vs), 32'd1);
    goto(142, VA0); chk("req_142", 32'(req), 32'd0);
    goto(143, VA0);
    chk("req_143", 32'(req), 32'd1);
    chk("px_143", 32'(px), 32'd0);
    chk("py_first", 32'(py), 32'd0);
    goto(144, VA0); chk("rgb_144", 32'(rgb), 32'h000);
    goto(782, VA0); chk("px_782", 32'(px), 32'd639);
    goto(783, VA0); chk("rgb_783", 32'(rgb), 32'h27F);
    goto(784, VA0);
    chk("rgb_784", 32'(rgb), 32'h000);
    chk("req_784", 32'(req), 32'd0);
    goto(783, VA0 + VV - 1);
    chk("py_last", 32'(py), 32'(VV - 1));

    goto(200, 10);
    @(posedge clk);
    #2 kv = 1'b1; kin = 8'h1C;
    @(posedge clk);
    #2 kv = 1'b0;
    @(negedge clk);
`ifdef VGA_KEY_FRAME_SYNC_EN
    chk("key_held", 32'(kout), 32'h00);
`else
    chk("key_fast", 32'(kout), 32'h1C);
`endif
    goto(0, 0);
    chk("fs_pulse", 32'(fs), 32'd1);
    @(negedge clk);
    chk("fs_drop", 32'(fs), 32'd0);
    chk("key_frame", 32'(kout), 32'h1C);

    rnd_on = 1'b1;
    goto(400, 12);
    rst = 1'b1;
    rnd_on = 1'b0;
    kv = 1'b0;
    @(negedge clk);
    chk("mid_rst_rgb", 32'(rgb), 32'd0);
    chk("mid_rst_req", 32'(req), 32'd0);
    n = $urandom_range(1, 4);
    repeat (n) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("restart_hs", 32'(hs), 32'd0);
    chk("restart_vs", 32'(vs), 32'd0);
    chk("restart_t", 32'(t), 32'd0);

    rnd_on = 1'b1;
    goto(799, VT - 1);
    quiet();
    kv = 1'b1; kin = 8'hA5;
    @(negedge clk);
    chk("fs_again", 32'(fs), 32'd1);
    @(posedge clk);
    #2 kv = 1'b0;
    @(negedge clk);
    chk("key_coincide", 32'(kout), 32'hA5);
    repeat (50) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
